pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter unit for the instruction fetch stage, replacing the fixed 32-bit load-on-clock PC. Each cycle it selects the next fetch address from sequential increment, branch, jump, call, return or exception redirect. It holds on stall and keeps a small circular return-address stack (RAS) to predict return targets. Output feeds instruction memory and the IF/ID pipeline register.

## Interface
- `WIDTH`, 32: address width in bits
- `INC`, 4: sequential increment in bytes; must be a power of two
- `RESET_VECTOR`, 0: PC value loaded on reset
- `EXC_VECTOR`, 32'h80000180: exception redirect address
- `RAS_DEPTH`, 4: return stack entries, power of two, at least 2
- `Clk`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Stall`  in  1  hold PC and RAS
- `Exception`  in  1  redirect to `EXC_VECTOR`
- `BranchTaken`  in  1  load `BranchTarget`
- `BranchTarget`  in  WIDTH  branch destination
- `Jump`  in  1  load `JumpTarget`
- `Call`  in  1  load `JumpTarget` and push `PCPlus`
- `JumpTarget`  in  WIDTH  jump/call destination
- `Return`  in  1  pop RAS and load the popped value
- `ReturnFallback`  in  WIDTH  target used when the RAS is empty (register-file `$ra`)
- `PCResult`  out  WIDTH  current fetch address
- `PCPlus`  out  WIDTH  `PCResult + INC` (combinational)
- `RasCount`  out  clog2(RAS_DEPTH)+1  valid RAS entries
- `RasEmpty`, `RasFull`  out  1  stack status flags
- `AlignErr`  out  1  registered; set if the last loaded target was misaligned

## Operation
- Next-PC priority, highest first:
  - Exception: `EXC_VECTOR`
  - Stall: hold
  - Return: RAS top, or `ReturnFallback` when `RasEmpty`
  - Call / Jump: `JumpTarget`
  - BranchTaken: `BranchTarget`
  - Otherwise: `PCPlus`
- Call pushes `PCPlus` of the current PC.
  - RAS full: overwrite the oldest entry (circular), `RasCount` stays at `RAS_DEPTH`.
- Return pops: `RasCount` decrements, saturating at 0.
  - When empty, the fallback target is used and the RAS is unchanged.
- Call and Return together: the Return target is used. The top entry is replaced by `PCPlus`; count is unchanged (or becomes 1 if the RAS was empty).
- Exception and Stall leave the RAS untouched.
- Lower-priority requests in the same cycle are ignored and not queued.
- Target alignment:
  - Loaded target with low clog2(INC) bits nonzero: those bits are cleared before loading and `AlignErr` is set for that cycle.
  - Otherwise `AlignErr` is 0.
  - Exception never sets `AlignErr`.
- Arithmetic is modulo 2^WIDTH: `PCPlus` wraps from all-ones-minus-INC+1 to 0 with no flag.

## Timing
- One-cycle latency: a selection made in cycle N appears on `PCResult` after the rising edge ending cycle N.
- `PCPlus` and the RAS-top read path are combinational from registered state.
- Reset is asynchronous assert and synchronous-edge release; outputs while and after Reset:
  - `PCResult` = `RESET_VECTOR`, `PCPlus` = `RESET_VECTOR + INC`
  - `RasCount` = 0, `RasEmpty` = 1, `RasFull` = 0, `AlignErr` = 0
  - RAS pointers are cleared; RAS contents are don't-care.
- Reset mid-operation discards any pending redirect; the first post-reset fetch is `RESET_VECTOR`.
- Inputs are sampled only on the rising edge and must be stable around it.

## Structure
- Shared package `pc_pkg`:
  - Next-PC select encoding: `PC_SEQ`, `PC_BR`, `PC_JMP`, `PC_RET`, `PC_EXC`, `PC_HOLD`
  - Default `RESET_VECTOR` / `EXC_VECTOR` constants
  - clog2 helper
- Sub-module `return_stack`:
  - Circular buffer with head pointer and saturating count.
  - Push, pop and push+pop (replace-top) ports; combinational top read.
- Top level: priority select, alignment masking, PC register.

## Test plan
- Reset with `RESET_VECTOR`=0x00400000, then release; 3 free-running cycles -> `PCResult` 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- `Stall` held 2 cycles at PC 0x100 -> PC stays 0x100; after release, 0x104. Exception raised during a stall -> PC becomes `EXC_VECTOR` on the next edge.
- Call to 0x2000 from PC 0x100 -> PC 0x2000 and RAS top 0x104. Later Return -> PC 0x104, `RasEmpty`=1. A further Return with `ReturnFallback`=0x3000 -> PC 0x3000.
- Five nested Calls with `RAS_DEPTH`=4 -> `RasFull`=1 and count 4; four Returns yield the last four pushed addresses in LIFO order, the oldest is lost.
- BranchTaken and Jump asserted together (targets 0x500 and 0x600) -> PC 0x600. `BranchTarget` 0x502 alone -> PC 0x500 with `AlignErr`=1 for one cycle.
- PC 0xFFFFFFFC free-running -> next PC 0x00000000. Assert `Reset` between clock edges -> `PCResult` becomes `RESET_VECTOR` immediately, without waiting for an edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: next-PC select codes,
// default vectors and an elaboration-time log2 helper.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_JMP,
        PC_RET,
        PC_EXC,
        PC_HOLD
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating count; top is a combinational read.
// Updates on the clock edge; push on full overwrites the oldest entry, push+pop replaces the top.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_dat,
    output logic [WIDTH-1:0]       o_top,
    output logic [clog2(DEPTH):0]  o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_head_inc;
    logic [PW-1:0]    w_head_dec;
    logic [PW-1:0]    w_wr_idx;

    assign w_head_inc = r_head + PW'(1);
    assign w_head_dec = r_head - PW'(1);
    // Push+pop rewrites the current top in place instead of advancing the head.
    assign w_wr_idx   = i_pop ? r_head : w_head_inc;

    assign o_top   = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    r_head <= w_head_inc;
                    if (!o_full) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                2'b01: begin
                    if (!o_empty) begin
                        r_head  <= w_head_dec;
                        r_count <= r_count - CW'(1);
                    end
                end
                2'b11: begin
                    if (o_empty) begin
                        r_count <= CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: prioritised next-PC select with alignment masking and a return stack.
// One-cycle latency from selection to PCResult; Stall holds PC and stack state.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       Exception,
    input  logic                       BranchTaken,
    input  logic [WIDTH-1:0]           BranchTarget,
    input  logic                       Jump,
    input  logic                       Call,
    input  logic [WIDTH-1:0]           JumpTarget,
    input  logic                       Return,
    input  logic [WIDTH-1:0]           ReturnFallback,
    output logic [WIDTH-1:0]           PCResult,
    output logic [WIDTH-1:0]           PCPlus,
    output logic [clog2(RAS_DEPTH):0]  RasCount,
    output logic                       RasEmpty,
    output logic                       RasFull,
    output logic                       AlignErr
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    logic [WIDTH-1:0] r_pc;
    logic             r_align_err;
    pc_sel_e          w_sel;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_loaded;
    logic             w_misalign;
    logic             w_active;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_ras_top;

    assign PCResult = r_pc;
    assign PCPlus   = r_pc + WIDTH'(INC);
    assign AlignErr = r_align_err;

    // Stack only moves when the cycle actually retires a call/return; an empty pop uses the fallback.
    assign w_active = !Exception && !Stall;
    assign w_push   = w_active && Call;
    assign w_pop    = w_active && Return && !RasEmpty;

    always_comb begin
        w_sel      = PC_SEQ;
        w_target   = PCPlus;
        w_loaded   = 1'b0;
        w_misalign = 1'b0;
        w_next_pc  = PCPlus;

        if (Exception)                w_sel = PC_EXC;
        else if (Stall)               w_sel = PC_HOLD;
        else if (Return)              w_sel = PC_RET;
        else if (Call || Jump)        w_sel = PC_JMP;
        else if (BranchTaken)         w_sel = PC_BR;

        case (w_sel)
            PC_EXC:  w_target = EXC_VECTOR;
            PC_HOLD: w_target = r_pc;
            PC_RET:  w_target = RasEmpty ? ReturnFallback : w_ras_top;
            PC_JMP:  w_target = JumpTarget;
            PC_BR:   w_target = BranchTarget;
            default: w_target = PCPlus;
        endcase

        w_loaded   = (w_sel == PC_RET) || (w_sel == PC_JMP) || (w_sel == PC_BR);
        w_misalign = w_loaded && |(w_target & ALIGN_MASK);
        w_next_pc  = w_loaded ? (w_target & ~ALIGN_MASK) : w_target;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc        <= RESET_VECTOR;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_align_err <= w_misalign;
        end
    end

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (PCPlus),
        .o_top   (w_ras_top),
        .o_count (RasCount),
        .o_empty (RasEmpty),
        .o_full  (RasFull)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_VECTOR 0x00400000 and a 4-entry return stack.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Exception;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic        Call;
    logic [31:0] JumpTarget;
    logic        Return;
    logic [31:0] ReturnFallback;
    logic [31:0] PCResult;
    logic [31:0] PCPlus;
    logic [2:0]  RasCount;
    logic        RasEmpty;
    logic        RasFull;
    logic        AlignErr;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] RV  = 32'h0040_0000;
    localparam logic [31:0] EXC = 32'h8000_0180;

    pc_sequencer #(
        .WIDTH        (32),
        .INC          (4),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EXC),
        .RAS_DEPTH    (4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .Exception      (Exception),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .Jump           (Jump),
        .Call           (Call),
        .JumpTarget     (JumpTarget),
        .Return         (Return),
        .ReturnFallback (ReturnFallback),
        .PCResult       (PCResult),
        .PCPlus         (PCPlus),
        .RasCount       (RasCount),
        .RasEmpty       (RasEmpty),
        .RasFull        (RasFull),
        .AlignErr       (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        Stall = 0; Exception = 0; BranchTaken = 0; Jump = 0; Call = 0; Return = 0;
    endtask

    logic [31:0] pushed [5];

    initial begin
        Reset = 1'b1;
        clear_ctl();
        BranchTarget = '0; JumpTarget = '0; ReturnFallback = '0;
        #2;
        chk("rst_pc",    PCResult, RV);
        chk("rst_plus",  PCPlus, RV + 32'd4);
        chk("rst_cnt",   {29'd0, RasCount}, 32'd0);
        chk("rst_empty", {31'd0, RasEmpty}, 32'd1);
        chk("rst_full",  {31'd0, RasFull}, 32'd0);
        chk("rst_align", {31'd0, AlignErr}, 32'd0);
        step(); step();
        Reset = 1'b0;
        chk("post_rst_pc", PCResult, RV);
        step(); chk("seq1", PCResult, 32'h0040_0004);
        step(); chk("seq2", PCResult, 32'h0040_0008);
        step(); chk("seq3", PCResult, 32'h0040_000C);

        // Stall holds, release resumes sequential fetch
        Jump = 1; JumpTarget = 32'h100;
        step(); chk("jmp100", PCResult, 32'h100);
        Jump = 0; Stall = 1;
        step(); chk("stall1", PCResult, 32'h100);
        step(); chk("stall2", PCResult, 32'h100);
        Stall = 0;
        step(); chk("unstall", PCResult, 32'h104);

        // Exception beats stall
        Jump = 1; JumpTarget = 32'h100;
        step(); Jump = 0;
        Stall = 1; Exception = 1;
        step(); chk("exc_in_stall", PCResult, EXC);
        chk("exc_align", {31'd0, AlignErr}, 32'd0);
        clear_ctl();

        // Call / return / fallback
        Jump = 1; JumpTarget = 32'h100;
        step(); Jump = 0;
        Call = 1; JumpTarget = 32'h2000;
        step(); Call = 0;
        chk("call_pc",  PCResult, 32'h2000);
        chk("call_cnt", {29'd0, RasCount}, 32'd1);
        chk("call_nonempty", {31'd0, RasEmpty}, 32'd0);
        step(); chk("call_seq", PCResult, 32'h2004);
        Return = 1;
        step();
        chk("ret_pc", PCResult, 32'h104);
        chk("ret_empty", {31'd0, RasEmpty}, 32'd1);
        ReturnFallback = 32'h3000;
        step();
        chk("ret_fallback", PCResult, 32'h3000);
        chk("ret_fb_cnt", {29'd0, RasCount}, 32'd0);
        Return = 0;

        // Five nested calls into a 4-deep stack
        for (int k = 0; k < 5; k++) begin
            pushed[k] = PCResult + 32'd4;
            Call = 1; JumpTarget = 32'h1000 + 32'(k) * 32'h100;
            step();
        end
        Call = 0;
        chk("nest_pc",   PCResult, 32'h1400);
        chk("nest_full", {31'd0, RasFull}, 32'd1);
        chk("nest_cnt",  {29'd0, RasCount}, 32'd4);
        ReturnFallback = 32'hDEAD_0000;
        Return = 1;
        for (int k = 4; k >= 1; k--) begin
            step();
            chk($sformatf("lifo%0d", k), PCResult, pushed[k]);
        end
        chk("lifo_empty", {31'd0, RasEmpty}, 32'd1);
        step();
        chk("oldest_lost", PCResult, 32'hDEAD_0000);
        Return = 0;

        // Call and Return together replace the top entry
        Call = 1; JumpTarget = 32'h7000;
        step();
        Return = 1; JumpTarget = 32'h8000;
        step();
        chk("callret_pc",  PCResult, 32'hDEAD_0004);
        chk("callret_cnt", {29'd0, RasCount}, 32'd1);
        Call = 0;
        step();
        chk("callret_pop", PCResult, 32'h7004);
        Return = 0;

        // Jump beats branch; misaligned branch is masked and flagged for one cycle
        BranchTaken = 1; BranchTarget = 32'h500; Jump = 1; JumpTarget = 32'h600;
        step(); chk("jmp_over_br", PCResult, 32'h600);
        Jump = 0; BranchTarget = 32'h502;
        step();
        chk("br_masked", PCResult, 32'h500);
        chk("br_alignerr", {31'd0, AlignErr}, 32'd1);
        BranchTaken = 0;
        step();
        chk("br_next", PCResult, 32'h504);
        chk("alignerr_clr", {31'd0, AlignErr}, 32'd0);

        // Address wrap
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step(); Jump = 0;
        chk("wrap_plus", PCPlus, 32'h0);
        step(); chk("wrap_pc", PCResult, 32'h0);

        // Asynchronous reset between edges, with a pending redirect discarded
        Jump = 1; JumpTarget = 32'h900;
        #2;
        Reset = 1;
        #1;
        chk("async_rst_pc", PCResult, RV);
        chk("async_rst_cnt", {29'd0, RasCount}, 32'd0);
        step();
        Reset = 0; Jump = 0;
        chk("rst_release_pc", PCResult, RV);
        step(); chk("rst_first_seq", PCResult, RV + 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
